song_sequencer: RTL and testbench

Playback controller for the song library. Selects a song in the library via `song_num`, then walks its 56 packed note slots in order, MSB slot first. For each slot it presents note and octave to the tone generator and holds them for the slot's duration. Provides play, pause and stop control plus busy and done status to the top-level UI.

---
 rtl/song_sequencer.sv | 162 ++++++++++++++++
 tb/tb_song_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: walks the 56 packed note slots of the selected song, holding each one for duration*BEAT_TICKS cycles.
// Optional feature macro: SEQ_LOOP_EN (replay the song from slot 0 instead of returning to IDLE).
module song_sequencer #(
    parameter int unsigned BEAT_TICKS = 12_500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   song_sel,
    input  logic         start,
    input  logic         pause,
    input  logic         stop,
    input  logic [223:0] song_packed,
    input  logic [223:0] time_continue,
    input  logic [111:0] octave_packed,
    output logic [1:0]   song_num,
    output logic [3:0]   note,
    output logic [1:0]   octave,
    output logic         note_valid,
    output logic [5:0]   index,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);

    localparam int TW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_RELOAD = TW'(BEAT_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE    = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PLAY  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_song_num;
    logic [3:0]      r_note;
    logic [1:0]      r_octave;
    logic            r_note_valid;
    logic [5:0]      r_index;
    logic            r_done;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_dur_cnt;

    // Slot 0 sits in the MSBs, so address the library from the top down.
    logic [5:0] w_slot_rev;
    logic [7:0] w_nbase;
    logic [6:0] w_obase;
    logic [3:0] w_code;
    logic [3:0] w_dur;
    logic [1:0] w_oct;
    logic       w_skip;
    logic       w_last;
    logic       w_is_tone;
    logic       w_note_tone;
    logic       w_slot_end;
    logic       w_end;

    assign w_slot_rev  = 6'd55 - r_index;
    assign w_nbase     = {w_slot_rev, 2'b00};
    assign w_obase     = {w_slot_rev, 1'b0};
    assign w_code      = song_packed[w_nbase +: 4];
    assign w_dur       = time_continue[w_nbase +: 4];
    assign w_oct       = octave_packed[w_obase +: 2];
    assign w_skip      = (w_code == 4'hF) || (w_dur == 4'd0);
    assign w_last      = (r_index == 6'd55);
    assign w_is_tone   = (w_code >= 4'd1) && (w_code <= 4'd7);
    assign w_note_tone = (r_note >= 4'd1) && (r_note <= 4'd7);
    assign w_slot_end  = (r_tick_cnt == '0) && (r_dur_cnt == 4'd0);
    // The song ends either on a skipped final slot or when the final played slot expires.
    assign w_end       = ((r_state == S_LOAD) && w_skip && w_last) ||
                         ((r_state == S_PLAY) && w_slot_end && w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_song_num   <= 2'b00;
            r_note       <= 4'd0;
            r_octave     <= 2'd0;
            r_note_valid <= 1'b0;
            r_index      <= 6'd0;
            r_done       <= 1'b0;
            r_tick_cnt   <= '0;
            r_dur_cnt    <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state      <= S_IDLE;
                r_note       <= 4'd0;
                r_octave     <= 2'd0;
                r_note_valid <= 1'b0;
                r_index      <= 6'd0;
                r_tick_cnt   <= '0;
                r_dur_cnt    <= 4'd0;
            end else if (w_end) begin
                r_done       <= 1'b1;
                r_note_valid <= 1'b0;
`ifdef SEQ_LOOP_EN
                r_index      <= 6'd0;
                r_state      <= S_LOAD;
`else
                r_state      <= S_IDLE;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && (song_sel != 2'b11)) begin
                            r_song_num <= song_sel;
                            r_index    <= 6'd0;
                            r_state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (w_skip) begin
                            r_index <= r_index + 6'd1;
                        end else begin
                            r_note       <= w_code;
                            r_octave     <= w_oct;
                            r_note_valid <= w_is_tone;
                            r_tick_cnt   <= TICK_RELOAD;
                            r_dur_cnt    <= w_dur - 4'd1;
                            r_state      <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (pause) begin
                            r_state      <= S_PAUSE;
                            r_note_valid <= 1'b0;
                        end else if (w_slot_end) begin
                            r_index <= r_index + 6'd1;
                            r_state <= S_LOAD;
                        end else if (r_tick_cnt == '0) begin
                            r_tick_cnt <= TICK_RELOAD;
                            r_dur_cnt  <= r_dur_cnt - 4'd1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt - TICK_ONE;
                        end
                    end
                    S_PAUSE: begin
                        // Counters stay frozen; the tone comes back exactly where it stopped.
                        if (!pause) begin
                            r_state      <= S_PLAY;
                            r_note_valid <= w_note_tone;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign song_num   = r_song_num;
    assign note       = r_note;
    assign octave     = r_octave;
    assign note_valid = r_note_valid;
    assign index      = r_index;
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a small song library model drives three songs; slot, done and stop events are scored
// against hand-computed records queued before each scenario.
module tb_song_sequencer;

    localparam int BT = 4;
    localparam int W  = 31;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    logic         clk;
    logic         rst_n;
    logic [1:0]   song_sel;
    logic         start;
    logic         pause;
    logic         stop;
    logic [223:0] lib_notes;
    logic [223:0] lib_durs;
    logic [111:0] lib_octs;
    logic [1:0]   song_num;
    logic [3:0]   note;
    logic [1:0]   octave;
    logic         note_valid;
    logic [5:0]   index;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    song_sequencer #(.BEAT_TICKS(BT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .song_sel      (song_sel),
        .start         (start),
        .pause         (pause),
        .stop          (stop),
        .song_packed   (lib_notes),
        .time_continue (lib_durs),
        .octave_packed (lib_octs),
        .song_num      (song_num),
        .note          (note),
        .octave        (octave),
        .note_valid    (note_valid),
        .index         (index),
        .busy          (busy),
        .done          (done),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- song library model ----------------
    // Returns {code, duration, octave} for slot i of song s.
    function automatic logic [9:0] slot_def(input logic [1:0] s, input int i);
        logic [9:0] r;
        r = {4'hF, 4'd1, 2'd0};
        case (s)
            2'd0: begin
                if (i == 0)           r = {4'h0, 4'd3, 2'd0};
                else if (i == 1)      r = {4'h2, 4'd5, 2'd0};
                else if (i == 2)      r = {4'h8, 4'd2, 2'd1};
                else if (i == 55)     r = {4'h1, 4'd1, 2'd2};
                else if (i % 2 == 0)  r = {4'hF, 4'd1, 2'd0};
                else                  r = {4'h4, 4'd0, 2'd0};
            end
            2'd1: begin
                if (i == 6)           r = {4'h0, 4'd1, 2'd0};
                else if (i == 7)      r = {4'h3, 4'd6, 2'd1};
                else                  r = {4'hF, 4'd2, 2'd0};
            end
            2'd2: begin
                if (i == 30)          r = {4'h7, 4'd4, 2'd1};
                else                  r = {4'hF, 4'd3, 2'd0};
            end
            default: r = {4'hF, 4'd1, 2'd0};
        endcase
        return r;
    endfunction

    always_comb begin
        lib_notes = '0;
        lib_durs  = '0;
        lib_octs  = '0;
        for (int i = 0; i < 56; i++) begin : g_slot
            logic [9:0] d;
            d = slot_def(song_num, i);
            lib_notes[223-4*i -: 4] = d[9:6];
            lib_durs[223-4*i -: 4]  = d[5:2];
            lib_octs[111-2*i -: 2]  = d[1:0];
        end
    end

    // ---------------- record packing ----------------
    // kind 0 = played slot, 1 = done pulse, 2 = stop back to IDLE
    function automatic logic [W-1:0] rec(input logic [1:0] k, input logic [5:0] idx, input logic [3:0] n,
                                         input logic [1:0] o, input logic v, input logic [5:0] ld,
                                         input logic [9:0] len);
        return {k, idx, n, o, v, ld, len};
    endfunction

    function automatic logic [W-1:0] done_rec();
`ifdef SEQ_LOOP_EN
        return rec(2'd1, 6'd0, 4'd0, 2'd0, 1'b1, 6'd0, 10'd0);
`else
        return rec(2'd1, 6'd55, 4'd0, 2'd0, 1'b0, 6'd0, 10'd0);
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_event(input logic [W-1:0] got, input string name);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event got=%h required=none", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got=%h required=%h", name, got, e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d required=%0d", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [1:0]   m_prev;
    logic         m_in_slot;
    logic [W-1:0] m_cap;
    int           m_len;
    int           m_loads;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev    = ST_IDLE;
            m_in_slot = 1'b0;
            m_len     = 0;
            m_loads   = 0;
        end else begin
            if (dbg_state == ST_LOAD) m_loads++;
            if (dbg_state == ST_PLAY) begin
                if (m_prev == ST_LOAD) begin
                    m_in_slot = 1'b1;
                    m_len     = 1;
                    m_cap     = rec(2'd0, index, note, octave, note_valid, 6'(m_loads), 10'd0);
                    m_loads   = 0;
                end else begin
                    m_len++;
                end
            end
            if ((m_prev == ST_PLAY || m_prev == ST_PAUSE) &&
                (dbg_state == ST_LOAD || dbg_state == ST_IDLE) && m_in_slot) begin
                check_event({m_cap[W-1:10], 10'(m_len)}, "slot");
                m_in_slot = 1'b0;
            end
            if (done) begin
                check_event(rec(2'd1, index, 4'd0, 2'd0, busy, 6'd0, 10'd0), "done");
                m_loads = 0;
            end
            if (m_prev != ST_IDLE && dbg_state == ST_IDLE && !done)
                check_event(rec(2'd2, index, note, octave, note_valid, {5'd0, busy}, 10'd0), "stop");
            if (dbg_state == ST_IDLE) m_loads = 0;
            m_prev = dbg_state;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_song(input logic [1:0] s);
        song_sel = s;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_play_idx(input logic [5:0] idx, input int budget);
        int c = 0;
        while (!(dbg_state == ST_PLAY && index == idx) && c < budget) begin
            tick(1);
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL wait_play_%0d: got=timeout required=slot playing", idx);
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got=%0d pending events required=0", exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic finish_song(input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            tick(1);
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL wait_done: got=timeout required=done pulse");
        end
`ifdef SEQ_LOOP_EN
        exp_q.push_back(rec(2'd2, 6'd0, 4'd0, 2'd0, 1'b0, 6'd0, 10'd0));
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
`endif
        drain(100);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int cnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        stop     = 1'b0;
        song_sel = 2'd0;
        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_note_valid", 32'(note_valid), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_song_num", 32'(song_num), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // start with song_sel = 3 is ignored
        start_song(2'd3);
        tick(2);
        chk("sel3_busy", 32'(busy), 32'd0);
        chk("sel3_song_num", 32'(song_num), 32'd0);

        // asynchronous reset while song 1 slot 7 plays
        exp_q.push_back(rec(2'd0, 6'd6, 4'd0, 2'd0, 1'b0, 6'd7, 10'd4));
        start_song(2'd1);
        wait_play_idx(6'd7, 200);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_note", 32'(note), 32'd0);
        chk("arst_octave", 32'(octave), 32'd0);
        chk("arst_note_valid", 32'(note_valid), 32'd0);
        chk("arst_index", 32'(index), 32'd0);
        chk("arst_song_num", 32'(song_num), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("arst_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        drain(50);

        // song 1: six skipped slots, a one-beat rest, a six-beat note, then skips to the end
        exp_q.push_back(rec(2'd0, 6'd6, 4'd0, 2'd0, 1'b0, 6'd7, 10'd4));
        exp_q.push_back(rec(2'd0, 6'd7, 4'd3, 2'd1, 1'b1, 6'd1, 10'd24));
        exp_q.push_back(done_rec());
        start_song(2'd1);
        finish_song(400);

        // song 0 with a 10-cycle pause inside slot 1 and an ignored start
        // slot 1 length includes the one frozen PLAY cycle in which pause was sampled
        exp_q.push_back(rec(2'd0, 6'd0, 4'd0, 2'd0, 1'b0, 6'd1, 10'd12));
        exp_q.push_back(rec(2'd0, 6'd1, 4'd2, 2'd0, 1'b1, 6'd1, 10'd21));
        exp_q.push_back(rec(2'd0, 6'd2, 4'd8, 2'd1, 1'b0, 6'd1, 10'd8));
        exp_q.push_back(rec(2'd0, 6'd55, 4'd1, 2'd2, 1'b1, 6'd53, 10'd4));
        exp_q.push_back(done_rec());
        start_song(2'd0);
        wait_play_idx(6'd1, 100);
        tick(7);
        pause = 1'b1;
        tick(1);
        chk("pause_note_valid", 32'(note_valid), 32'd0);
        chk("pause_note", 32'(note), 32'd2);
        chk("pause_index", 32'(index), 32'd1);
        start_song(2'd2);
        chk("busy_start_song_num", 32'(song_num), 32'd0);
        tick(8);
        pause = 1'b0;
        tick(1);
        chk("resume_note_valid", 32'(note_valid), 32'd1);
        cnt = 0;
        while (dbg_state == ST_PLAY && cnt < 100) begin
            cnt++;
            tick(1);
        end
        chk("resume_play_cycles", 32'(cnt), 32'd13);
        chk("after_slot1_index", 32'(index), 32'd2);
        finish_song(400);

        // song 2: stop five cycles into slot 30
        exp_q.push_back(rec(2'd0, 6'd30, 4'd7, 2'd1, 1'b1, 6'd31, 10'd5));
        exp_q.push_back(rec(2'd2, 6'd0, 4'd0, 2'd0, 1'b0, 6'd0, 10'd0));
        start_song(2'd2);
        wait_play_idx(6'd30, 200);
        tick(4);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_song_num", 32'(song_num), 32'd2);
        chk("stop_index", 32'(index), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        tick(5);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
